// File: rtl/tlul_mem_responder.sv
// TL-UL device endpoint: word-addressed register-array memory answering Get/Put
// requests through a 2-entry registered response FIFO.
module tlul_mem_responder #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DBW   = DW / 8,
  parameter int SZW   = $clog2($clog2(DBW) + 1),
  parameter int AIW   = 8,
  parameter int DIW   = 1,
  parameter int DUW   = 16,
  parameter int Depth = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           a_valid_i,
  output logic           a_ready_o,
  input  logic [2:0]     a_opcode_i,
  input  logic [2:0]     a_param_i,
  input  logic [SZW-1:0] a_size_i,
  input  logic [AIW-1:0] a_source_i,
  input  logic [AW-1:0]  a_address_i,
  input  logic [DBW-1:0] a_mask_i,
  input  logic [DW-1:0]  a_data_i,
  output logic           d_valid_o,
  input  logic           d_ready_i,
  output logic [2:0]     d_opcode_o,
  output logic [2:0]     d_param_o,
  output logic [SZW-1:0] d_size_o,
  output logic [AIW-1:0] d_source_o,
  output logic [DIW-1:0] d_sink_o,
  output logic [DW-1:0]  d_data_o,
  output logic [DUW-1:0] d_user_o,
  output logic           d_error_o
);

  localparam int IW   = $clog2(Depth);
  localparam int OFFW = $clog2(DBW);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  typedef struct packed {
    logic [2:0]     opcode;
    logic [SZW-1:0] size;
    logic [AIW-1:0] source;
    logic [DW-1:0]  data;
    logic           error;
  } rsp_t;

  // Byte lanes touched by a transfer of 2^size bytes starting at lane off.
  function automatic logic [DBW-1:0] lane_mask(input logic [SZW-1:0] size,
                                               input logic [OFFW-1:0] off);
    logic [DBW:0] full;
    full = (DBW+1)'(1) << (32'd1 << size);
    full = full - (DBW+1)'(1);
    return full[DBW-1:0] << off;
  endfunction

  function automatic logic misaligned(input logic [SZW-1:0] size,
                                      input logic [OFFW-1:0] off);
    logic [OFFW-1:0] low;
    low = OFFW'((32'd1 << size) - 32'd1);
    return (off & low) != '0;
  endfunction

  logic [DW-1:0]   mem [Depth];
  rsp_t            fifo_p1 [2];
  logic            wr_ptr_p1;
  logic            rd_ptr_p1;
  logic [1:0]      count_p1;

  logic [OFFW-1:0] off_p0;
  logic [IW-1:0]   idx_p0;
  logic [DBW-1:0]  lanes_p0;
  logic            is_get_p0;
  logic            is_pfull_p0;
  logic            is_ppart_p0;
  logic            err_p0;
  logic            vld_p0;
  logic            pop_p0;
  rsp_t            rsp_p0;

  // Stage 0: decode and check the A-channel request, form its response.
  assign off_p0      = a_address_i[OFFW-1:0];
  assign idx_p0      = a_address_i[IW+OFFW-1:OFFW];
  assign lanes_p0    = lane_mask(a_size_i, off_p0);
  assign is_get_p0   = a_opcode_i == OP_GET;
  assign is_pfull_p0 = a_opcode_i == OP_PUT_FULL;
  assign is_ppart_p0 = a_opcode_i == OP_PUT_PART;

  assign err_p0 = !(is_get_p0 || is_pfull_p0 || is_ppart_p0)
               || (a_param_i != 3'd0)
               || (a_size_i > SZW'(OFFW))
               || misaligned(a_size_i, off_p0)
               || (a_address_i[AW-1:IW+OFFW] != '0)
               || ((a_mask_i & ~lanes_p0) != '0)
               || (is_pfull_p0 && (a_mask_i != lanes_p0))
               || ((is_get_p0 || is_ppart_p0) && (a_mask_i == '0));

  assign a_ready_o = ~count_p1[1];
  assign vld_p0    = a_valid_i && a_ready_o;
  assign pop_p0    = d_valid_o && d_ready_i;

  always_comb begin
    rsp_p0        = '0;
    rsp_p0.opcode = is_get_p0 ? OP_ACK_DATA : OP_ACK;
    rsp_p0.size   = a_size_i;
    rsp_p0.source = a_source_i;
    rsp_p0.error  = err_p0;
    if (is_get_p0) rsp_p0.data = err_p0 ? '1 : mem[idx_p0];
  end

  // Stage 1: memory update and response FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_p1 <= 1'b0;
      rd_ptr_p1 <= 1'b0;
      count_p1  <= 2'd0;
      fifo_p1[0] <= '0;
      fifo_p1[1] <= '0;
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else begin
      if (vld_p0) begin
        fifo_p1[wr_ptr_p1] <= rsp_p0;
        wr_ptr_p1          <= ~wr_ptr_p1;
        if (!is_get_p0 && !err_p0) begin
          for (int b = 0; b < DBW; b++)
            if (a_mask_i[b]) mem[idx_p0][8*b +: 8] <= a_data_i[8*b +: 8];
        end
      end
      if (pop_p0) rd_ptr_p1 <= ~rd_ptr_p1;
      count_p1 <= count_p1 + {1'b0, vld_p0} - {1'b0, pop_p0};
    end
  end

  assign d_valid_o  = count_p1 != 2'd0;
  assign d_opcode_o = fifo_p1[rd_ptr_p1].opcode;
  assign d_size_o   = fifo_p1[rd_ptr_p1].size;
  assign d_source_o = fifo_p1[rd_ptr_p1].source;
  assign d_data_o   = fifo_p1[rd_ptr_p1].data;
  assign d_error_o  = fifo_p1[rd_ptr_p1].error;
  assign d_param_o  = 3'd0;
  assign d_sink_o   = '0;
  assign d_user_o   = '0;

endmodule

// File: tb/tb_tlul_mem_responder.sv
// Scoreboard bench for tlul_mem_responder: requests push expected responses,
// a D-channel monitor pops and compares them in order.
module tb_tlul_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode, d_param;
  logic [1:0]  d_size;
  logic [7:0]  d_source;
  logic [0:0]  d_sink;
  logic [31:0] d_data;
  logic [15:0] d_user;
  logic        d_error;

  always #5 clk = ~clk;

  tlul_mem_responder dut (
    .clk_i(clk), .rst_ni(rst_n),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_opcode_i(a_opcode),
    .a_param_i(a_param), .a_size_i(a_size), .a_source_i(a_source),
    .a_address_i(a_address), .a_mask_i(a_mask), .a_data_i(a_data),
    .d_valid_o(d_valid), .d_ready_i(d_ready), .d_opcode_o(d_opcode),
    .d_param_o(d_param), .d_size_o(d_size), .d_source_o(d_source),
    .d_sink_o(d_sink), .d_data_o(d_data), .d_user_o(d_user), .d_error_o(d_error)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
    logic        err;
    logic [7:0]  src;
    logic [1:0]  size;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mdl [16];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always @(posedge clk) cyc++;

  // D-channel monitor: every handshake must match the oldest expected response.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && d_valid === 1'b1 && d_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got op=%0d data=%h src=%h required no response", d_opcode, d_data, d_source);
      end else begin
        mon_e = sb.pop_front();
        if ({d_opcode, d_data, d_error, d_source, d_size, d_param, d_sink, d_user} !==
            {mon_e.op, mon_e.data, mon_e.err, mon_e.src, mon_e.size, 3'd0, 1'b0, 16'd0}) begin
          errors++;
          $display("FAIL rsp_payload got op=%0d data=%h err=%b src=%h size=%0d prm=%0d sink=%0d user=%h required op=%0d data=%h err=%b src=%h size=%0d",
                   d_opcode, d_data, d_error, d_source, d_size, d_param, d_sink, d_user,
                   mon_e.op, mon_e.data, mon_e.err, mon_e.src, mon_e.size);
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge with a_valid still high.
  task automatic send(input logic [2:0] op, input logic [2:0] prm, input logic [1:0] sz,
                      input logic [7:0] src, input logic [31:0] addr, input logic [3:0] msk,
                      input logic [31:0] dat, input logic exp_err);
    exp_t e;
    int   n;
    a_valid = 1'b1; a_opcode = op; a_param = prm; a_size = sz; a_source = src;
    a_address = addr; a_mask = msk; a_data = dat;
    n = 0;
    @(negedge clk);
    while (a_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (a_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL accept_timeout got a_ready=%b required 1 within 50 cycles", a_ready);
      a_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.op   = (op == 3'd4) ? 3'd1 : 3'd0;
    e.err  = exp_err;
    e.src  = src;
    e.size = sz;
    if (op == 3'd4) e.data = exp_err ? 32'hFFFF_FFFF : mdl[addr[5:2]];
    else            e.data = 32'h0;
    if (op != 3'd4 && !exp_err)
      for (int b = 0; b < 4; b++)
        if (msk[b]) mdl[addr[5:2]][8*b +: 8] = dat[8*b +: 8];
    sb.push_back(e);
    #1;
  endtask

  task automatic drain();
    int n;
    a_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_valid = 1'b0; d_ready = 1'b1;
    a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
    a_address = '0; a_mask = '0; a_data = '0;
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({d_valid, d_opcode, d_data, d_error, d_source, d_size} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b op=%0d data=%h err=%b src=%h size=%0d required all 0",
               d_valid, d_opcode, d_data, d_error, d_source, d_size);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got a_ready=%b d_valid=%b required 1 0", a_ready, d_valid);
    end
  endtask

  task automatic test_put_get();
    d_ready = 1'b1;
    a_valid = 1'b1; a_opcode = 3'd0; a_param = 3'd0; a_size = 2'd2; a_source = 8'h5A;
    a_address = 32'h8; a_mask = 4'hF; a_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (d_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_no_comb got d_valid=%b required 0", d_valid);
    end
    send(3'd0, 3'd0, 2'd2, 8'h5A, 32'h8, 4'hF, 32'hDEADBEEF, 1'b0);
    checks++;
    if (d_valid !== 1'b1 || d_opcode !== 3'd0 || d_source !== 8'h5A || d_error !== 1'b0) begin
      errors++;
      $display("FAIL put_full_ack got v=%b op=%0d src=%h err=%b required 1 0 5a 0", d_valid, d_opcode, d_source, d_error);
    end
    send(3'd4, 3'd0, 2'd2, 8'h11, 32'h8, 4'hF, 32'h0, 1'b0);
    a_valid = 1'b0;
    checks++;
    if (d_opcode !== 3'd1 || d_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL get_after_put got op=%0d data=%h required 1 deadbeef", d_opcode, d_data);
    end
    drain();
    send(3'd1, 3'd0, 2'd2, 8'h12, 32'h8, 4'b0010, 32'h0000_5500, 1'b0);
    send(3'd4, 3'd0, 2'd2, 8'h13, 32'h8, 4'hF, 32'h0, 1'b0);
    a_valid = 1'b0;
    checks++;
    if (d_data !== 32'hDEAD55EF) begin
      errors++;
      $display("FAIL put_partial got data=%h required dead55ef", d_data);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] held;
    d_ready = 1'b0;
    send(3'd4, 3'd0, 2'd2, 8'h01, 32'h8, 4'hF, 32'h0, 1'b0);
    send(3'd4, 3'd0, 2'd2, 8'h02, 32'h0, 4'hF, 32'h0, 1'b0);
    fork
      send(3'd4, 3'd0, 2'd2, 8'h03, 32'h4, 4'hF, 32'h0, 1'b0);
      begin
        @(negedge clk);
        held = d_data;
        checks++;
        if (a_ready !== 1'b0) begin
          errors++;
          $display("FAIL full_ready got a_ready=%b required 0", a_ready);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (d_valid !== 1'b1 || d_data !== held || d_source !== 8'h01) begin
          errors++;
          $display("FAIL stall_hold got v=%b data=%h src=%h required 1 %h 01", d_valid, d_data, d_source, held);
        end
        @(posedge clk);
        #1;
        d_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b0) begin
          errors++;
          $display("FAIL pop_same_cycle got a_ready=%b required 0", a_ready);
        end
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1) begin
          errors++;
          $display("FAIL ready_after_pop got a_ready=%b required 1", a_ready);
        end
      end
    join
    drain();
  endtask

  task automatic test_errors();
    d_ready = 1'b1;
    send(3'd4, 3'd0, 2'd2, 8'h20, 32'h40, 4'hF, 32'h0, 1'b1);
    send(3'd4, 3'd0, 2'd2, 8'h21, 32'h2, 4'hF, 32'h0, 1'b1);
    send(3'd3, 3'd0, 2'd2, 8'h22, 32'h8, 4'hF, 32'h0, 1'b1);
    send(3'd0, 3'd0, 2'd1, 8'h23, 32'h8, 4'hF, 32'h1234_5678, 1'b1);
    send(3'd0, 3'd1, 2'd2, 8'h24, 32'h8, 4'hF, 32'h1111_1111, 1'b1);
    send(3'd1, 3'd0, 2'd2, 8'h25, 32'h8, 4'h0, 32'h2222_2222, 1'b1);
    send(3'd1, 3'd0, 2'd0, 8'h26, 32'h9, 4'b0100, 32'h3333_3333, 1'b1);
    send(3'd4, 3'd0, 2'd2, 8'h27, 32'h8, 4'hF, 32'h0, 1'b0);
    a_valid = 1'b0;
    checks++;
    if (d_data !== 32'hDEAD55EF) begin
      errors++;
      $display("FAIL err_mem_unchanged got data=%h required dead55ef", d_data);
    end
    drain();
    send(3'd0, 3'd0, 2'd1, 8'h28, 32'hA, 4'b1100, 32'hCAFE_0000, 1'b0);
    send(3'd1, 3'd0, 2'd0, 8'h29, 32'h8, 4'b0001, 32'h0000_0077, 1'b0);
    send(3'd4, 3'd0, 2'd0, 8'h2A, 32'hB, 4'b1000, 32'h0, 1'b0);
    a_valid = 1'b0;
    checks++;
    if (d_data !== 32'hCAFE5577) begin
      errors++;
      $display("FAIL subword_ops got data=%h required cafe5577", d_data);
    end
    drain();
  endtask

  task automatic test_stream();
    int start;
    d_ready = 1'b1;
    start = cyc;
    for (int i = 0; i < 16; i++)
      send(3'd0, 3'd0, 2'd2, 8'(i), 32'(i * 4), 4'hF, $urandom, 1'b0);
    for (int i = 0; i < 16; i++)
      send(3'd4, 3'd0, 2'd2, 8'(i + 16), 32'(i * 4), 4'hF, 32'h0, 1'b0);
    a_valid = 1'b0;
    checks++;
    if (cyc - start != 32) begin
      errors++;
      $display("FAIL stream_rate got %0d cycles required 32", cyc - start);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    d_ready = 1'b0;
    send(3'd0, 3'd0, 2'd2, 8'h40, 32'h4, 4'hF, 32'hA5A5_A5A5, 1'b0);
    send(3'd4, 3'd0, 2'd2, 8'h41, 32'h4, 4'hF, 32'h0, 1'b0);
    a_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (d_valid !== 1'b0 || d_data !== 32'h0 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async got v=%b data=%h a_ready=%b required 0 0 1", d_valid, d_data, a_ready);
    end
    sb.delete();
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    d_ready = 1'b1;
    @(posedge clk);
    #1;
    send(3'd4, 3'd0, 2'd2, 8'h42, 32'h4, 4'hF, 32'h0, 1'b0);
    a_valid = 1'b0;
    checks++;
    if (d_data !== 32'h0 || d_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mem_clear got v=%b data=%h required 1 0", d_valid, d_data);
    end
    send(3'd4, 3'd0, 2'd2, 8'h43, 32'h8, 4'hF, 32'h0, 1'b0);
    send(3'd4, 3'd0, 2'd2, 8'h44, 32'h3C, 4'hF, 32'h0, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_put_get();
    test_back_to_back();
    test_errors();
    test_stream();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no completion required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tlul_mem_responder.md
# tlul_mem_responder

Device-side (responder) endpoint of the 32-bit TL-UL bus used by the DV environment: accepts A-channel Get/PutFullData/PutPartialData requests, services them from a small word-addressed register-array memory, and returns AccessAck/AccessAckData on the D channel through a 2-entry response FIFO. It is the target that host-side agents and the core's LSU/fetch ports talk to in block-level benches. Bus widths match the project bus parameters (32-bit address/data, 4 byte lanes, 8-bit source, 1-bit sink, 16-bit D user).

## Interface
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- DBW, DW/8, byte-lane mask width
- SZW, $clog2($clog2(DBW)+1), size field width (2)
- AIW, 8, source ID width
- DIW, 1, sink ID width
- DUW, 16, D-channel user width
- Depth, 16, memory depth in DW-bit words (power of 2, ≥2)

- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- a_valid_i  in  1  request valid
- a_ready_o  out  1  request accepted when high with a_valid_i
- a_opcode_i  in  3  0 PutFullData, 1 PutPartialData, 4 Get
- a_param_i  in  3  must be 0
- a_size_i  in  SZW  log2 bytes (0..2)
- a_source_i  in  AIW  requester ID
- a_address_i  in  AW  byte address
- a_mask_i  in  DBW  byte enables
- a_data_i  in  DW  write data
- d_valid_o  out  1  response valid
- d_ready_i  in  1  response consumed when high with d_valid_o
- d_opcode_o  out  3  0 AccessAck, 1 AccessAckData
- d_param_o  out  3  always 0
- d_size_o  out  SZW  echo of a_size_i
- d_source_o  out  AIW  echo of a_source_i
- d_sink_o  out  DIW  always 0
- d_data_o  out  DW  read data (0 for AccessAck)
- d_user_o  out  DUW  always 0
- d_error_o  out  1  request rejected

## Operation
- Accept: a_valid_i && a_ready_o; a_ready_o = (fifo count < 2), independent of a_valid_i and d_ready_i.
- Word index = a_address_i[$clog2(Depth)+1:2]; offset = a_address_i[1:0].
- Error if any: opcode ∉ {0,1,4}; a_param_i ≠ 0; a_size_i > 2; offset not aligned to 2^a_size_i; a_address_i ≥ Depth*4; mask has bits outside the lanes covered by size/offset; PutFullData mask ≠ exactly the covered lanes; Get/PutPartialData mask = 0.
- Legal Get: push {AccessAckData, data = mem[index] (full word, all lanes), error 0}.
- Legal Put*: write lanes where a_mask_i set; push {AccessAck, data 0, error 0}.
- Error Get: AccessAckData, data 32'hFFFF_FFFF, error 1. Error Put: AccessAck, data 0, error 1, memory unchanged.
- Every entry carries size/source echoes; param, sink, user tied 0.
- D channel: head of FIFO; pop on d_valid_o && d_ready_i. Responses strictly in acceptance order.
- Payload held stable while d_valid_o && !d_ready_i.

## Timing
- Reset: memory all 0, FIFO empty, d_valid_o 0, a_ready_o 1 after reset release, all d_* outputs 0.
- Latency: request accepted in cycle N → d_valid_o in N+1 (registered FIFO, no combinational A→D path).
- Read data sampled at acceptance: Put in cycle N then Get in N+1 returns the new data; Get in N then Put in N+1 returns old data.
- Throughput: 1 request/cycle while d_ready_i held high.
- Full (count 2): a_ready_o 0; a pop in the same cycle does not enable acceptance that cycle (a_ready_o rises next cycle).
- Simultaneous push and pop at count 1: count stays 1, new entry becomes head next cycle.
- Reset asserted mid-transaction: FIFO flushed, pending responses dropped, memory cleared, outputs to reset values immediately (async).

## Test plan
- PutFullData addr 0x8, size 2, mask 4'hF, data 0xDEADBEEF, source 0x5A → AccessAck, error 0, source 0x5A, d_valid next cycle; Get 0x8 → AccessAckData 0xDEADBEEF.
- PutPartialData addr 0x8 mask 4'b0010 data 0x0000_5500 over 0xDEADBEEF → Get returns 0xDEAD55EF.
- Hold d_ready_i 0, issue 3 back-to-back Gets → a_ready_o drops after 2 accepts; release d_ready_i → 3 responses in order, third accepted only after a pop.
- Errors: Get addr 0x40 (Depth 16), size 2 at addr 0x2, opcode 3, PutFullData size 1 mask 4'hF → each d_error_o 1; error Get data 0xFFFFFFFF; memory unchanged.
- Streaming: 16 Puts then 16 Gets with d_ready_i 1 → one response per cycle, latency 1, data matches.
- Reset asserted with 2 pending responses → d_valid_o 0 immediately; after release Get any address returns 0.
